spi_sram_bridge: RTL and testbench

- Parametrised bus-to-SPI-SRAM bridge for CPU-driven designs.
- Accepts single-byte read/write requests on a stall-style request/ready bus and runs the SPI SRAM command protocol itself.
- Generalised in address width, SPI clock divider, fast-read mode, burst limits and CS idle timeout.
- Holds chip-select low across sequential accesses in either direction, so consecutive addresses skip the command and address phases.

---
 rtl/spi_sram_pkg.sv | 31 +++
 rtl/spi_bit_engine.sv | 73 +++++++
 rtl/spi_sram_bridge.sv | 197 +++++++++++++++++++
 tb/tb_spi_sram_bridge.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_sram_pkg.sv
// Shared types and constants for the SPI SRAM bridge: FSM states, SRAM opcodes and
// an address-byte extraction helper.
package spi_sram_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StCmd,
    StAddr,
    StDummy,
    StData,
    StDone,
    StHold,
    StGap
  } state_e;

  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] CMD_WRITE = 8'h02;
  localparam logic [7:0] CMD_FREAD = 8'h0B;

  localparam int unsigned DUMMY_BITS = 8;
  localparam int unsigned MAX_ADDR_W = 24;

  // Byte idx (0 = least significant) of a zero-extended address.
  function automatic logic [7:0] addr_byte(input logic [MAX_ADDR_W-1:0] addr,
                                           input logic [1:0] idx);
    logic [MAX_ADDR_W-1:0] sh;
    sh = addr >> {idx, 3'b000};
    return sh[7:0];
  endfunction

endpackage

// File: rtl/spi_bit_engine.sv
// SPI mode-0 byte shifter: SCLK_DIV clk cycles per bit, MSB first, miso sampled on the
// first cycle of the sclk-high half. A load on the byte_done cycle keeps bits contiguous.
module spi_bit_engine #(
  parameter int unsigned SCLK_DIV = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_i,
  input  logic [7:0] data_i,
  input  logic       miso_i,
  output logic       sclk_o,
  output logic       mosi_o,
  output logic       byte_done_o,
  output logic [7:0] rx_byte_o
);

  localparam int unsigned PhW = (SCLK_DIV > 2) ? $clog2(SCLK_DIV) : 1;
  localparam logic [PhW-1:0] PhHalf = PhW'(SCLK_DIV / 2);
  localparam logic [PhW-1:0] PhLast = PhW'(SCLK_DIV - 1);

  logic           busy_q, busy_d;
  logic [PhW-1:0] phase_q, phase_d;
  logic [2:0]     bit_q, bit_d;
  logic [7:0]     tx_q, tx_d;
  logic [7:0]     rx_q, rx_d;
  logic           sample, last;

  always_comb begin
    sample      = busy_q && (phase_q == PhHalf);
    last        = busy_q && (phase_q == PhLast);
    byte_done_o = last && (bit_q == 3'd7);
    // Includes the bit being sampled this cycle so the caller sees the full byte at byte_done.
    rx_byte_o   = sample ? {rx_q[6:0], miso_i} : rx_q;
    sclk_o      = busy_q && (phase_q >= PhHalf);
    mosi_o      = busy_q && tx_q[7];

    busy_d  = busy_q;
    phase_d = phase_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    rx_d    = rx_byte_o;
    if (load_i) begin
      busy_d  = 1'b1;
      phase_d = '0;
      bit_d   = '0;
      tx_d    = data_i;
    end else if (last) begin
      phase_d = '0;
      bit_d   = bit_q + 3'd1;
      tx_d    = {tx_q[6:0], 1'b0};
      if (bit_q == 3'd7) busy_d = 1'b0;
    end else if (busy_q) begin
      phase_d = phase_q + PhW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q  <= 1'b0;
      phase_q <= '0;
      bit_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
    end else begin
      busy_q  <= busy_d;
      phase_q <= phase_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
    end
  end

endmodule

// File: rtl/spi_sram_bridge.sv
// Byte-wide request/ready bus to SPI SRAM bridge. Keeps cs_n low between accesses so that
// sequential same-direction requests skip the command and address phases.
module spi_sram_bridge
  import spi_sram_pkg::*;
#(
  parameter int unsigned ADDR_W       = 24,
  parameter int unsigned ADDR_BYTES   = 3,
  parameter int unsigned SCLK_DIV     = 2,
  parameter bit          RBURST_EN    = 1'b1,
  parameter bit          WBURST_EN    = 1'b1,
  parameter bit          FAST_READ    = 1'b0,
  parameter int unsigned MAX_BURST    = 0,
  parameter int unsigned IDLE_TIMEOUT = 0,
  parameter int unsigned CS_HIGH_MIN  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_en,
  input  logic              mem_wr,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_wdata,
  output logic              mem_rdy,
  output logic [7:0]        mem_rdata,
  output logic              cs_n,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso
);

  localparam logic [1:0] LastByte = 2'(ADDR_BYTES - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   next_addr_q, next_addr_d;
  logic                wr_q, wr_d;
  logic [7:0]          wdata_q, wdata_d;
  logic [7:0]          rdata_q, rdata_d;
  logic [1:0]          byte_idx_q, byte_idx_d;
  logic [31:0]         burst_q, burst_d;
  logic [31:0]         idle_q, idle_d;
  logic [31:0]         gap_q, gap_d;
  logic                cs_n_q;

  logic                eng_load, eng_done;
  logic [7:0]          eng_data, eng_rx;
  logic [MAX_ADDR_W-1:0] addr_ext;
  logic                accept_fresh, dir_en, cont_ok;

  spi_bit_engine #(
    .SCLK_DIV(SCLK_DIV)
  ) u_engine (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (eng_load),
    .data_i     (eng_data),
    .miso_i     (miso),
    .sclk_o     (sclk),
    .mosi_o     (mosi),
    .byte_done_o(eng_done),
    .rx_byte_o  (eng_rx)
  );

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    next_addr_d  = next_addr_q;
    wr_d         = wr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    byte_idx_d   = byte_idx_q;
    burst_d      = burst_q;
    idle_d       = '0;
    gap_d        = '0;
    eng_load     = 1'b0;
    eng_data     = '0;
    accept_fresh = 1'b0;

    addr_ext               = '0;
    addr_ext[ADDR_W-1:0]   = addr_q;

    dir_en  = mem_wr ? WBURST_EN : RBURST_EN;
    cont_ok = (mem_wr == wr_q) && (mem_addr == next_addr_q) && dir_en &&
              ((MAX_BURST == 0) || (burst_q < MAX_BURST));

    unique case (state_q)
      StIdle: accept_fresh = mem_en;
      StCmd: begin
        if (eng_done) begin
          eng_load   = 1'b1;
          eng_data   = addr_byte(addr_ext, LastByte);
          byte_idx_d = LastByte;
          state_d    = StAddr;
        end
      end
      StAddr: begin
        if (eng_done) begin
          eng_load = 1'b1;
          if (byte_idx_q != 2'd0) begin
            eng_data   = addr_byte(addr_ext, byte_idx_q - 2'd1);
            byte_idx_d = byte_idx_q - 2'd1;
          end else if (!wr_q && FAST_READ) begin
            state_d = StDummy;
          end else begin
            eng_data = wr_q ? wdata_q : 8'h00;
            state_d  = StData;
          end
        end
      end
      StDummy: begin
        if (eng_done) begin
          eng_load = 1'b1;
          state_d  = StData;
        end
      end
      StData: begin
        if (eng_done) begin
          if (!wr_q) rdata_d = eng_rx;
          state_d = StDone;
        end
      end
      StDone: begin
        if (burst_q != '1) burst_d = burst_q + 32'd1;
        next_addr_d = addr_q + ADDR_W'(1);
        state_d     = StHold;
      end
      StHold: begin
        idle_d = idle_q + 32'd1;
        // A request wins over a timeout expiring in the same cycle.
        if (mem_en) begin
          if (cont_ok) begin
            addr_d   = mem_addr;
            wr_d     = mem_wr;
            wdata_d  = mem_wdata;
            eng_load = 1'b1;
            eng_data = mem_wr ? mem_wdata : 8'h00;
            state_d  = StData;
          end else begin
            state_d = StGap;
          end
        end else if ((IDLE_TIMEOUT != 0) && (idle_q == IDLE_TIMEOUT - 1)) begin
          state_d = StGap;
        end
      end
      StGap: begin
        gap_d = gap_q + 32'd1;
        if (gap_q + 32'd1 >= CS_HIGH_MIN) begin
          if (mem_en) accept_fresh = 1'b1;
          else        state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (accept_fresh) begin
      addr_d   = mem_addr;
      wr_d     = mem_wr;
      wdata_d  = mem_wdata;
      burst_d  = '0;
      eng_load = 1'b1;
      eng_data = mem_wr ? CMD_WRITE : (FAST_READ ? CMD_FREAD : CMD_READ);
      state_d  = StCmd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      next_addr_q <= '0;
      wr_q        <= 1'b0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      byte_idx_q  <= '0;
      burst_q     <= '0;
      idle_q      <= '0;
      gap_q       <= '0;
      cs_n_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      next_addr_q <= next_addr_d;
      wr_q        <= wr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      byte_idx_q  <= byte_idx_d;
      burst_q     <= burst_d;
      idle_q      <= idle_d;
      gap_q       <= gap_d;
      cs_n_q      <= (state_d == StIdle) || (state_d == StGap);
    end
  end

  assign mem_rdy   = (state_q == StDone);
  assign mem_rdata = rdata_q;
  assign cs_n      = cs_n_q;

endmodule

// File: tb/tb_spi_sram_bridge.sv
// Directed bench for spi_sram_bridge: a default instance and a 16-bit fast-read instance
// with burst limit and idle timeout, each with a small SPI SRAM slave model.
module tb_spi_sram_bridge;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] mem_en, mem_wr, mem_rdy, cs_n, sclk, mosi, miso;
  logic [23:0] mem_addr [2];
  logic [7:0]  mem_wdata [2];
  logic [7:0]  mem_rdata [2];

  always #5 clk = ~clk;

  spi_sram_bridge u_dut0 (
    .clk      (clk),
    .rst_n    (rst_n),
    .mem_en   (mem_en[0]),
    .mem_wr   (mem_wr[0]),
    .mem_addr (mem_addr[0]),
    .mem_wdata(mem_wdata[0]),
    .mem_rdy  (mem_rdy[0]),
    .mem_rdata(mem_rdata[0]),
    .cs_n     (cs_n[0]),
    .sclk     (sclk[0]),
    .mosi     (mosi[0]),
    .miso     (miso[0])
  );

  spi_sram_bridge #(
    .ADDR_W      (16),
    .ADDR_BYTES  (2),
    .FAST_READ   (1'b1),
    .MAX_BURST   (2),
    .IDLE_TIMEOUT(5)
  ) u_dut1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .mem_en   (mem_en[1]),
    .mem_wr   (mem_wr[1]),
    .mem_addr (mem_addr[1][15:0]),
    .mem_wdata(mem_wdata[1]),
    .mem_rdy  (mem_rdy[1]),
    .mem_rdata(mem_rdata[1]),
    .cs_n     (cs_n[1]),
    .sclk     (sclk[1]),
    .mosi     (mosi[1]),
    .miso     (miso[1])
  );

  // Slave model: logs every mosi byte of a cs_n-low window, returns mbyte on miso.
  logic [7:0] mbyte [2];
  logic [7:0] mlog [2][64];
  int         mcnt [2];
  int         wbits [2];
  logic [7:0] sh [2];
  logic [1:0] psclk;
  logic [2:0] bsel;

  initial begin
    for (int i = 0; i < 2; i++) begin
      mcnt[i]  = 0;
      wbits[i] = 0;
      sh[i]    = '0;
    end
    psclk = '0;
    miso  = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (cs_n[i]) begin
          wbits[i] = 0;
          sh[i]    = '0;
        end else begin
          if (sclk[i] && !psclk[i]) begin
            sh[i] = {sh[i][6:0], mosi[i]};
            if (wbits[i] % 8 == 7) begin
              mlog[i][6'(mcnt[i])] = sh[i];
              mcnt[i]++;
            end
          end
          if (!sclk[i] && psclk[i]) wbits[i]++;
        end
        psclk[i] = sclk[i];
        bsel     = 3'(7 - wbits[i] % 8);
        miso[i]  = mbyte[i][bsel];
      end
    end
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Latency is counted from the cycle the request is first presented.
  task automatic bus_xfer(input int i, input logic wr, input logic [23:0] addr,
                          input logic [7:0] wd, input logic [7:0] mb,
                          output int lat, output int cs_hi);
    mbyte[i]     = mb;
    mem_wr[i]    = wr;
    mem_addr[i]  = addr;
    mem_wdata[i] = wd;
    mem_en[i]    = 1'b1;
    lat   = 0;
    cs_hi = 0;
    while (lat < 300) begin
      tick();
      lat++;
      if (cs_n[i]) cs_hi++;
      if (mem_rdy[i]) break;
    end
    mem_en[i] = 1'b0;
  endtask

  task automatic chk_log(input string tag, input int i, input int mark, input int n,
                         input logic [63:0] exp);
    logic [63:0] s;
    check({tag, ".nbytes"}, mcnt[i] - mark, n);
    for (int j = 0; j < n; j++) begin
      s = exp >> (8 * (n - 1 - j));
      check($sformatf("%s.byte%0d", tag, j), {24'h0, mlog[i][6'(mark + j)]}, {24'h0, s[7:0]});
    end
  endtask

  int lat, hi, mark, n;

  initial begin
    mem_en = '0;
    mem_wr = '0;
    for (int i = 0; i < 2; i++) begin
      mem_addr[i]  = '0;
      mem_wdata[i] = '0;
      mbyte[i]     = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    check("rst.cs_n", cs_n[0], 1);
    check("rst.sclk", sclk[0], 0);
    check("rst.mosi", mosi[0], 0);
    check("rst.rdy", mem_rdy[0], 0);
    check("rst.rdata", mem_rdata[0], 0);
    check("rst.cs_n1", cs_n[1], 1);
    rst_n = 1'b1;
    tick();

    // Fresh read from IDLE.
    mark = mcnt[0];
    bus_xfer(0, 1'b0, 24'h001234, 8'h00, 8'hA5, lat, hi);
    check("rd1.lat", lat, 81);
    check("rd1.rdata", mem_rdata[0], 8'hA5);
    chk_log("rd1.mosi", 0, mark, 5, 64'h03_00_12_34_00);

    // Non-sequential read forces a GAP, then two continuations.
    tick();
    mark = mcnt[0];
    bus_xfer(0, 1'b0, 24'h000100, 8'h00, 8'h11, lat, hi);
    check("b0.lat", lat, 83);
    check("b0.cshi", hi, 2);
    check("b0.rdata", mem_rdata[0], 8'h11);
    tick();
    bus_xfer(0, 1'b0, 24'h000101, 8'h00, 8'h22, lat, hi);
    check("b1.lat", lat, 17);
    check("b1.cshi", hi, 0);
    check("b1.rdata", mem_rdata[0], 8'h22);
    tick();
    bus_xfer(0, 1'b0, 24'h000102, 8'h00, 8'h33, lat, hi);
    check("b2.lat", lat, 17);
    check("b2.cshi", hi, 0);
    check("b2.rdata", mem_rdata[0], 8'h33);
    chk_log("burst.mosi", 0, mark, 7, 64'h03_00_01_00_00_00_00);

    // Direction changes never continue, even at the next address.
    tick();
    mark = mcnt[0];
    bus_xfer(0, 1'b1, 24'h000020, 8'h10, 8'h00, lat, hi);
    check("wr.lat", lat, 83);
    check("wr.cshi", hi, 2);
    check("wr.rdata_kept", mem_rdata[0], 8'h33);
    chk_log("wr.mosi", 0, mark, 5, 64'h02_00_00_20_10);
    tick();
    mark = mcnt[0];
    bus_xfer(0, 1'b0, 24'h000021, 8'h00, 8'h5A, lat, hi);
    check("rdw.lat", lat, 83);
    check("rdw.cshi", hi, 2);
    check("rdw.rdata", mem_rdata[0], 8'h5A);
    chk_log("rdw.mosi", 0, mark, 5, 64'h03_00_00_21_00);

    // Instance 1: burst limit of 2, then idle timeout.
    tick();
    mark = mcnt[1];
    bus_xfer(1, 1'b1, 24'h0000, 8'hA0, 8'h00, lat, hi);
    check("mb0.lat", lat, 65);
    tick();
    bus_xfer(1, 1'b1, 24'h0001, 8'hA1, 8'h00, lat, hi);
    check("mb1.lat", lat, 17);
    check("mb1.cshi", hi, 0);
    chk_log("mb01.mosi", 1, mark, 5, 64'h02_00_00_A0_A1);
    tick();
    mark = mcnt[1];
    bus_xfer(1, 1'b1, 24'h0002, 8'hA2, 8'h00, lat, hi);
    check("mb2.lat", lat, 67);
    check("mb2.cshi", hi, 2);
    chk_log("mb2.mosi", 1, mark, 4, 64'h02_00_02_A2);
    n = 0;
    while (n < 20) begin
      tick();
      n++;
      if (cs_n[1]) break;
    end
    check("tmo.cycles", n, 6);
    repeat (5) tick();

    // Fast read at the top of a 16-bit space, then wrap to 0 as a continuation.
    mark = mcnt[1];
    bus_xfer(1, 1'b0, 24'h00FFFF, 8'h00, 8'h3C, lat, hi);
    check("fr0.lat", lat, 81);
    check("fr0.rdata", mem_rdata[1], 8'h3C);
    chk_log("fr0.mosi", 1, mark, 5, 64'h0B_FF_FF_00_00);
    tick();
    mark = mcnt[1];
    bus_xfer(1, 1'b0, 24'h000000, 8'h00, 8'hC3, lat, hi);
    check("fr1.lat", lat, 17);
    check("fr1.cshi", hi, 0);
    check("fr1.rdata", mem_rdata[1], 8'hC3);
    chk_log("fr1.mosi", 1, mark, 1, 64'h00);

    // Asynchronous reset in the middle of the ADDR phase.
    tick();
    mbyte[0]    = 8'h00;
    mem_wr[0]   = 1'b0;
    mem_addr[0] = 24'h000040;
    mem_en[0]   = 1'b1;
    repeat (30) tick();
    check("mid.cs_n", cs_n[0], 0);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst.cs_n", cs_n[0], 1);
    check("arst.sclk", sclk[0], 0);
    check("arst.mosi", mosi[0], 0);
    check("arst.rdy", mem_rdy[0], 0);
    check("arst.rdata", mem_rdata[0], 0);
    mem_en[0] = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    mark = mcnt[0];
    bus_xfer(0, 1'b0, 24'h000005, 8'h00, 8'h96, lat, hi);
    check("post.lat", lat, 81);
    check("post.rdata", mem_rdata[0], 8'h96);
    chk_log("post.mosi", 0, mark, 5, 64'h03_00_00_05_00);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
